// File: rtl/meas_frame_tx.sv
// meas_frame_tx: serialises one measurement frame into a byte-wide UART.
// Frame: 0xAA, type byte, 0/1/3 words MSB first, XOR checksum.
module meas_frame_tx (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  mode,
   input  logic        is_high,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic        tx_busy,
   output logic [7:0]  dataout,
   output logic        wrsig,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP,
      WAIT
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic [1:0]  mode_q;
   logic        high_q;
   logic [31:0] w0;
   logic [31:0] w1;
   logic [31:0] w2;

   logic [3:0]  idx;
   logic [3:0]  nidx;
   logic [3:0]  last_idx;
   logic [3:0]  dofs;
   logic [7:0]  csum;
   logic [7:0]  type_b;
   logic [7:0]  data_b;
   logic [7:0]  next_b;
   logic [31:0] word;
   logic        gap_q;

   logic        launch;
   logic        advance;
   logic        finish;

   // Select the byte that follows the one currently on dataout.
   always_comb begin
      type_b = {5'b0, high_q, mode_q};
      nidx   = idx + 4'd1;
      dofs   = nidx - 4'd2;
      unique case (mode_q)
         2'b00:   last_idx = 4'd2;
         2'b01:   last_idx = 4'd6;
         default: last_idx = 4'd14;
      endcase
      unique case (dofs[3:2])
         2'b00:   word = w0;
         2'b01:   word = w1;
         default: word = w2;
      endcase
      unique case (dofs[1:0])
         2'b00:   data_b = word[31:24];
         2'b01:   data_b = word[23:16];
         2'b10:   data_b = word[15:8];
         default: data_b = word[7:0];
      endcase
      if (nidx == 4'd1)
         next_b = type_b;
      else if (nidx == last_idx)
         next_b = csum;
      else
         next_b = data_b;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nx = state;
      wrsig    = 1'b0;
      launch   = 1'b0;
      advance  = 1'b0;
      finish   = 1'b0;
      busy     = (state != IDLE);
      overrun  = start && (busy || frame_done);
      unique case (state)
         IDLE: begin
            // a start coinciding with frame_done is an overrun
            if (start && !frame_done) begin
               launch   = 1'b1;
               state_nx = SEND;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               wrsig    = 1'b1;
               state_nx = GAP;
            end
         end
         GAP: begin
            if (gap_q)
               state_nx = WAIT;
         end
         default: begin
            if (!tx_busy) begin
               if (idx == last_idx) begin
                  finish   = 1'b1;
                  state_nx = IDLE;
               end else begin
                  advance  = 1'b1;
                  state_nx = SEND;
               end
            end
         end
      endcase
   end

   // State register and gap timer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         gap_q <= 1'b0;
      end else begin
         state <= state_nx;
         gap_q <= (state == GAP) && !gap_q;
      end
   end

   // Frame datapath: latch inputs, load bytes, run checksum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q     <= 2'b00;
         high_q     <= 1'b0;
         w0         <= 32'h0;
         w1         <= 32'h0;
         w2         <= 32'h0;
         idx        <= 4'd0;
         csum       <= 8'h00;
         dataout    <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         frame_done <= finish;
         if (launch) begin
            mode_q  <= mode;
            high_q  <= is_high;
            w0      <= data0;
            w1      <= data1;
            w2      <= data2;
            idx     <= 4'd0;
            csum    <= 8'h00;
            dataout <= 8'hAA;
         end else if (advance) begin
            idx     <= nidx;
            dataout <= next_b;
            if (nidx != last_idx)
               csum <= csum ^ next_b;
         end else if (finish) begin
            idx <= 4'd0;
         end
      end
   end

endmodule

// File: doc/meas_frame_tx.md
MEAS_FRAME_TX -- requirements
Module: meas_frame_tx

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  one-cycle request to send one frame.
REQ-004 SHALL have ports: mode  in  2  input-count code: 00 none, 01 one signal, 10/11 two signals.
REQ-005 SHALL have ports: is_high  in  1  high-frequency path flag.
REQ-006 SHALL have ports: data0, data1, data2  in  32 each  measurement words.
REQ-007 SHALL have ports: tx_busy  in  1  UART transmitter busy.
REQ-008 SHALL have ports: dataout  out  8  byte presented to the UART.
REQ-009 SHALL have ports: wrsig  out  1  one-cycle byte write strobe.
REQ-010 SHALL have ports: busy  out  1  frame in progress.
REQ-011 SHALL have ports: frame_done  out  1  one-cycle pulse after the last byte completes.
REQ-012 SHALL have ports: overrun  out  1  one-cycle pulse when start is dropped.

Function
REQ-013 SHALL, on start while in IDLE, latch mode, is_high and data0..2 in the same edge; later input changes SHALL NOT affect the frame.
REQ-014 SHALL send the word count N = 0 for mode 00, 1 for mode 01, and 3 for mode 10/11.
REQ-015 SHALL send bytes in this order: 0xAA header; type byte {5'b0, is_high, mode}; words data0..data(N-1), each MSB first (4 bytes per word); checksum.
REQ-016 SHALL form the checksum as the XOR of the type byte and all data bytes; the header SHALL be excluded.
REQ-017 SHALL send frame lengths of 3, 7 or 15 bytes for N = 0, 1, 3.
REQ-018 SHALL use FSM states IDLE, SEND, GAP, WAIT.
- IDLE -> SEND on start.
- SEND: when tx_busy=0, assert wrsig for one cycle with dataout valid in that cycle, then -> GAP.
- GAP: hold exactly 2 cycles with tx_busy ignored, then -> WAIT.
- WAIT: when tx_busy=0, go -> SEND if bytes remain, else -> IDLE and pulse frame_done.
REQ-019 SHALL hold dataout stable from the wrsig cycle until the next wrsig.
REQ-020 SHALL never assert wrsig while tx_busy=1; a SEND cycle with tx_busy=1 SHALL stall.
REQ-021 SHALL assert busy in every state except IDLE.
REQ-022 SHALL deassert busy in the cycle that frame_done pulses.
REQ-023 SHALL ignore start arriving while busy=1 and pulse overrun in that cycle; the frame in flight SHALL be unaffected.
REQ-024 SHALL treat start arriving in the same cycle as frame_done as an overrun, not a new frame.
REQ-025 SHALL keep the byte index in 4 bits (0..14) and reset it to 0 on entry to IDLE.
REQ-026 SHALL update the running checksum when each byte is loaded and clear it at start.
REQ-027 SHALL separate consecutive wrsig pulses by at least 4 cycles.

Reset
REQ-028 SHALL, on reset=0 and regardless of clk, force state to IDLE, set dataout=8'h00, and clear wrsig, busy, frame_done, overrun, the byte index, the checksum and the latched registers.
REQ-029 SHALL, on reset mid-frame, abandon the frame: no further wrsig, and no frame_done for it.
REQ-030 SHALL require a fresh start after reset release to begin a new frame.

Verification
REQ-031 The bench SHALL cover: mode=00, is_high=0, tx_busy held 0 -> bytes AA 00 00; frame_done once; busy low afterwards.
REQ-032 The bench SHALL cover: mode=01, is_high=1, data0=32'h12345678 -> bytes AA 05 12 34 56 78 checksum=0x05^0x12^0x34^0x56^0x78=0x0D.
REQ-033 The bench SHALL cover: mode=10, data0=1, data1=2, data2=3 -> 15 bytes, words in order 00000001 00000002 00000003, checksum 0x02; data changed after start SHALL have no effect.
REQ-034 The bench SHALL cover: tx_busy high for 50 cycles after each wrsig -> no wrsig while tx_busy=1; byte sequence unchanged.
REQ-035 The bench SHALL cover: start repeated mid-frame, and start in the frame_done cycle -> one overrun pulse each; only one frame sent.
REQ-036 The bench SHALL cover: reset=0 after byte 4 of a 15-byte frame -> outputs at reset values immediately; after release, no wrsig until a new start; the next frame is complete and correct.
